// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with per-register busy scoreboard and registered dual read
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding on both read ports).
// Register 0 and any address >= NREGS read as zero, never go busy, and ignore writes/reservations.

module register_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            re_i,
  input  logic [AW-1:0]   a1_i,
  input  logic [AW-1:0]   a2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  output logic            rvalid_o,
  output logic            busy1_o,
  output logic            busy2_o,
  input  logic            we3_i,
  input  logic [AW-1:0]   a3_i,
  input  logic [XLEN-1:0] wd3_i,
  input  logic            rsv_i,
  input  logic [AW-1:0]   rsv_a_i,
  output logic [AW:0]     pending_o
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // An address names a real, writable register only if it is in range and non-zero.
  function automatic logic legal(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && (a != '0);
  endfunction

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      pending_d;
  logic             wr_ok;
  logic             rsv_ok;
  logic [XLEN-1:0]  rd1_d;
  logic [XLEN-1:0]  rd2_d;
  logic             b1_d;
  logic             b2_d;

  assign wr_ok  = we3_i && legal(a3_i);
  assign rsv_ok = rsv_i && legal(rsv_a_i);

  // Next busy vector: a write retires its register, then a reservation (which wins on collision) sets one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wr_ok && (a3_i == AW'(i))) busy_d[i] = 1'b0;
      if (rsv_ok && (rsv_a_i == AW'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pending count is the population count of the next busy vector, so it moves on the same edge as the bits.
  always_comb begin
    pending_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      pending_d = pending_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // Read port muxes: stored data (or forwarded write data) and post-edge busy state; zero for register 0 / out of range.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    b1_d  = 1'b0;
    b2_d  = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (a1_i == AW'(i)) begin
        rd1_d = regs_q[i];
        b1_d  = busy_d[i];
      end
      if (a2_i == AW'(i)) begin
        rd2_d = regs_q[i];
        b2_d  = busy_d[i];
      end
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (a1_i == a3_i)) rd1_d = wd3_i;
    if (wr_ok && (a2_i == a3_i)) rd2_d = wd3_i;
`else
    // Read-before-write: the stored (pre-write) value is returned when the read hits the write target.
`endif
  end

  // Register array storage; entry 0 is only ever cleared so it always reads zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_ok && (a3_i == AW'(i))) regs_q[i] <= wd3_i;
      end
    end
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q    <= '0;
      pending_o <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_o <= pending_d;
    end
  end

  // Registered read outputs: load on re_i, otherwise hold; rvalid_o marks the cycle after a read.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd1_o    <= '0;
      rd2_o    <= '0;
      busy1_o  <= 1'b0;
      busy2_o  <= 1'b0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) begin
        rd1_o   <= rd1_d;
        rd2_o   <= rd2_d;
        busy1_o <= b1_d;
        busy2_o <= b2_d;
      end
    end
  end

endmodule
